xadc_channel_analyzer: RTL and testbench
========================================

Name: xadc_channel_analyzer

Overview:
- Parametrised successor to the fixed 4-channel XADC reader.
- Autonomously polls NUM_CHANNELS XADC auxiliary result registers over the DRP port and averages 2^AVG_LOG2 samples per channel.
- Picks the winning (maximum-average) channel as the network classification and flags whether the winner clears a programmable threshold.
- Sits between axi_cfg_regs (enable, threshold, mode, status) and the XADC primitive, replacing xadc_interface.

Parameters:
- NUM_CHANNELS, 4, number of aux channels polled (1..16).
- AVG_LOG2, 2, log2 of samples averaged per decision (0..4).
- DRP_BASE_ADDR, 7'h10, DRP address of aux channel 0 result; channel c reads DRP_BASE_ADDR+c.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for DRDY before aborting (1..65535).
- Derived: IDX_W = max(1, clog2(NUM_CHANNELS)); ACC_W = 12+AVG_LOG2.

Ports:
- S_AXI_ACLK  in  1  sole clock, also drives XADC DCLK.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- enable  in  1  run analyzer.
- trigger_mode  in  1  0: start each round on EOS; 1: free-running.
- threshold  in  12  decision threshold for the winning average.
- timeout_clear  in  1  clears drp_timeout.
- DADDR  out  7  DRP address.
- DEN  out  1  DRP enable, single-cycle pulse.
- DI  out  16  DRP write data, tied 0.
- DWE  out  1  DRP write enable, tied 0.
- BUSY  in  1  XADC busy; informational, ignored.
- DO  in  16  DRP read data; result in DO[15:4].
- DRDY  in  1  DRP data ready.
- EOS  in  1  XADC end-of-sequence.
- network_output  out  IDX_W  index of the winning channel.
- network_valid  out  1  1-cycle pulse when a new decision is published.
- above_threshold  out  1  winner average >= threshold.
- channel_avg  out  NUM_CHANNELS*12  packed averages; channel c occupies bits [12c+11:12c].
- drp_timeout  out  1  sticky DRP timeout flag.

Behaviour:
- Reset: all outputs, accumulators, counters and the state register are 0; state goes to IDLE.
- DI and DWE are always 0 (read-only use of the DRP).
- States: IDLE, WAIT_TRIG, REQ, WAIT_RDY, DECIDE.
- IDLE: when enable=1, go to WAIT_TRIG with ch=0 and sample_cnt=0.
- WAIT_TRIG:
  - trigger_mode=1: go to REQ next cycle.
  - trigger_mode=0: go to REQ on the cycle after EOS is sampled high.
  - enable=0: go to IDLE.
- REQ: drive DEN=1 for exactly one cycle with DADDR=DRP_BASE_ADDR+ch; clear the timeout counter; go to WAIT_RDY.
- WAIT_RDY, on DRDY=1:
  - acc[ch] += DO[15:4].
  - If ch < NUM_CHANNELS-1: ch++ and go to REQ.
  - Else, if sample_cnt == 2^AVG_LOG2-1: go to DECIDE.
  - Else: sample_cnt++, ch=0, go to WAIT_TRIG.
- WAIT_RDY, timeout: if TIMEOUT_CYCLES elapse with no DRDY, set drp_timeout, clear all accumulators, ch and sample_cnt, and go to WAIT_TRIG. No decision is published.
- DRDY in any state other than WAIT_RDY is ignored.
- DECIDE (one cycle):
  - avg[c] = acc[c] >> AVG_LOG2, truncated.
  - Argmax over avg; on a tie the lowest index wins.
  - Register channel_avg, network_output, and above_threshold = (max_avg >= threshold), unsigned compare.
  - network_valid = 1 for this cycle only.
  - Clear accumulators, ch and sample_cnt; go to WAIT_TRIG, or IDLE if enable=0.
- Published outputs hold until the next DECIDE or reset.
- enable=0 mid-round:
  - An outstanding DRP read completes (wait for DRDY or timeout); no new DEN is issued.
  - Then clear accumulators and go to IDLE; no network_valid.
- Latency: network_valid asserts the cycle after the final DRDY of the last sample round.
- drp_timeout is cleared by timeout_clear. If timeout_clear and a new timeout occur in the same cycle, set wins.
- Accumulators are ACC_W bits and cannot overflow.

Test Plan:
- NUM_CHANNELS=4, AVG_LOG2=0, mode 1, DRP model returns DO[15:4]=0x100/0x800/0x300/0x200 for ch0..3 (DRDY 3 cycles after DEN), threshold=0x400 -> DADDR 0x10..0x13 in order, network_output=1, above_threshold=1, channel_avg=0x200_300_800_100, exactly one network_valid per round.
- All channels return 0x555, threshold=0x600 -> network_output=0 (tie rule), above_threshold=0.
- AVG_LOG2=2, ch0 returns 0x100, 0x200, 0x300, 0x400 over four rounds -> single valid after the 4th round, ch0 avg=0x280; no valid after rounds 1-3.
- DRP model withholds DRDY for ch2 -> drp_timeout=1 after 255 cycles, no valid, next DEN has DADDR=0x10; pulsing timeout_clear -> drp_timeout=0.
- Mode 0 with EOS held low -> DEN never asserts; single EOS pulse -> exactly one round of 4 DEN pulses.
- Async reset asserted during WAIT_RDY -> all outputs 0 immediately and DEN=0. enable dropped during ch1's read -> that read completes, no further DEN, no valid, state returns to IDLE.

Source files
------------

// File: rtl/xadc_channel_analyzer.sv
// Polls NUM_CHANNELS XADC aux results over DRP, averages 2^AVG_LOG2 samples per
// channel and publishes the maximum-average channel with a threshold flag.
module xadc_channel_analyzer #(
  parameter int          NUM_CHANNELS   = 4,
  parameter int          AVG_LOG2       = 2,
  parameter logic [6:0]  DRP_BASE_ADDR  = 7'h10,
  parameter int          TIMEOUT_CYCLES = 255,
  localparam int         IDX_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int         ACC_W          = 12 + AVG_LOG2
) (
  input  logic                      S_AXI_ACLK,
  input  logic                      S_AXI_ARESETN,
  input  logic                      enable,
  input  logic                      trigger_mode,
  input  logic [11:0]               threshold,
  input  logic                      timeout_clear,
  output logic [6:0]                DADDR,
  output logic                      DEN,
  output logic [15:0]               DI,
  output logic                      DWE,
  input  logic                      BUSY,
  input  logic [15:0]               DO,
  input  logic                      DRDY,
  input  logic                      EOS,
  output logic [IDX_W-1:0]          network_output,
  output logic                      network_valid,
  output logic                      above_threshold,
  output logic [NUM_CHANNELS*12-1:0] channel_avg,
  output logic                      drp_timeout
);

  localparam int                SCNT_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST  = SCNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [IDX_W-1:0]  CH_LAST    = IDX_W'(NUM_CHANNELS - 1);
  localparam logic [15:0]       TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TRIG = 3'd1,
    REQ       = 3'd2,
    WAIT_RDY  = 3'd3,
    DECIDE    = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            ch_q, ch_d;
  logic [SCNT_W-1:0]           scnt_q, scnt_d;
  logic [15:0]                 tmo_q, tmo_d;
  logic [ACC_W-1:0]            acc_q [NUM_CHANNELS];
  logic [ACC_W-1:0]            acc_d [NUM_CHANNELS];
  logic [ACC_W-1:0]            acc_upd [NUM_CHANNELS];
  logic                        den_q, den_d;
  logic [6:0]                  daddr_q, daddr_d;
  logic [IDX_W-1:0]            net_out_q, net_out_d;
  logic                        valid_q, valid_d;
  logic                        above_q, above_d;
  logic [NUM_CHANNELS*12-1:0]  avg_pack_q, avg_pack_d;
  logic                        tmo_flag_q, tmo_flag_d;

  logic [NUM_CHANNELS*12-1:0]  dec_pack;
  logic [IDX_W-1:0]            dec_idx;
  logic [11:0]                 dec_max;
  logic [11:0]                 avg_c;
  logic                        unused_ok;

  // Truncating divide by the sample count; the quotient always fits 12 bits.
  function automatic logic [11:0] acc_to_avg(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] shifted;
    shifted = acc >> AVG_LOG2;
    return shifted[11:0];
  endfunction

  always_comb begin
    acc_upd = acc_q;
    if (state_q == WAIT_RDY && DRDY) begin
      acc_upd[ch_q] = acc_q[ch_q] + ACC_W'(DO[15:4]);
    end
  end

  // Argmax over averages including the sample landing this cycle; strict '>' keeps the lowest index on ties.
  always_comb begin
    dec_pack = '0;
    dec_idx  = '0;
    dec_max  = acc_to_avg(acc_upd[0]);
    avg_c    = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      avg_c = acc_to_avg(acc_upd[c]);
      dec_pack[12*c +: 12] = avg_c;
      if (c > 0 && avg_c > dec_max) begin
        dec_max = avg_c;
        dec_idx = IDX_W'(c);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    scnt_d     = scnt_q;
    tmo_d      = tmo_q;
    acc_d      = acc_upd;
    den_d      = 1'b0;
    daddr_d    = daddr_q;
    net_out_d  = net_out_q;
    valid_d    = 1'b0;
    above_d    = above_q;
    avg_pack_d = avg_pack_q;
    tmo_flag_d = timeout_clear ? 1'b0 : tmo_flag_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = WAIT_TRIG;
          ch_d    = '0;
          scnt_d  = '0;
        end
      end
      WAIT_TRIG: begin
        if (!enable) begin
          state_d = IDLE;
          ch_d    = '0;
          scnt_d  = '0;
          for (int c = 0; c < NUM_CHANNELS; c++) acc_d[c] = '0;
        end else if (trigger_mode || EOS) begin
          state_d = REQ;
        end
      end
      REQ: begin
        state_d = WAIT_RDY;
        tmo_d   = '0;
      end
      WAIT_RDY: begin
        if (DRDY) begin
          if (!enable) begin
            state_d = IDLE;
            ch_d    = '0;
            scnt_d  = '0;
            for (int c = 0; c < NUM_CHANNELS; c++) acc_d[c] = '0;
          end else if (ch_q != CH_LAST) begin
            ch_d    = ch_q + 1'b1;
            state_d = REQ;
          end else if (scnt_q == SCNT_LAST) begin
            state_d    = DECIDE;
            net_out_d  = dec_idx;
            above_d    = (dec_max >= threshold);
            avg_pack_d = dec_pack;
            valid_d    = 1'b1;
          end else begin
            scnt_d  = scnt_q + 1'b1;
            ch_d    = '0;
            state_d = WAIT_TRIG;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_flag_d = 1'b1;
          ch_d       = '0;
          scnt_d     = '0;
          for (int c = 0; c < NUM_CHANNELS; c++) acc_d[c] = '0;
          state_d    = enable ? WAIT_TRIG : IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      DECIDE: begin
        ch_d    = '0;
        scnt_d  = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) acc_d[c] = '0;
        state_d = enable ? WAIT_TRIG : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == REQ) begin
      den_d   = 1'b1;
      daddr_d = DRP_BASE_ADDR + 7'(ch_d);
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      scnt_q     <= '0;
      tmo_q      <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) acc_q[c] <= '0;
      den_q      <= 1'b0;
      daddr_q    <= '0;
      net_out_q  <= '0;
      valid_q    <= 1'b0;
      above_q    <= 1'b0;
      avg_pack_q <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      scnt_q     <= scnt_d;
      tmo_q      <= tmo_d;
      acc_q      <= acc_d;
      den_q      <= den_d;
      daddr_q    <= daddr_d;
      net_out_q  <= net_out_d;
      valid_q    <= valid_d;
      above_q    <= above_d;
      avg_pack_q <= avg_pack_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign DADDR           = daddr_q;
  assign DEN             = den_q;
  assign DI              = '0;
  assign DWE             = 1'b0;
  assign network_output  = net_out_q;
  assign network_valid   = valid_q;
  assign above_threshold = above_q;
  assign channel_avg     = avg_pack_q;
  assign drp_timeout     = tmo_flag_q;

  // BUSY and the low status nibble of DO carry no information for this reader.
  assign unused_ok = ^{BUSY, DO[3:0]};

endmodule

// File: tb/tb_xadc_channel_analyzer.sv
// Randomized bench for xadc_channel_analyzer with a DRP responder and an
// averaging/argmax reference model computed from per-sample value tables.
module tb_xadc_channel_analyzer;

  localparam int NCH   = 4;
  localparam int NSAMP = 4;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        trigger_mode;
  logic [11:0] threshold;
  logic        timeout_clear;
  logic [6:0]  DADDR;
  logic        DEN;
  logic [15:0] DI;
  logic        DWE;
  logic        BUSY;
  logic [15:0] DO;
  logic        DRDY;
  logic        EOS;
  logic [1:0]  network_output;
  logic        network_valid;
  logic        above_threshold;
  logic [47:0] channel_avg;
  logic        drp_timeout;

  int checks;
  int failures;
  int cyc;
  int vld_cnt;
  int epoch;
  int lat;
  bit withhold_en;
  logic [6:0] withhold_addr;
  int tbl [NSAMP][NCH];
  logic [6:0] den_log [$];
  int den_cyc [$];

  xadc_channel_analyzer u_dut (
    .S_AXI_ACLK      (clk),
    .S_AXI_ARESETN   (rst_n),
    .enable          (enable),
    .trigger_mode    (trigger_mode),
    .threshold       (threshold),
    .timeout_clear   (timeout_clear),
    .DADDR           (DADDR),
    .DEN             (DEN),
    .DI              (DI),
    .DWE             (DWE),
    .BUSY            (BUSY),
    .DO              (DO),
    .DRDY            (DRDY),
    .EOS             (EOS),
    .network_output  (network_output),
    .network_valid   (network_valid),
    .above_threshold (above_threshold),
    .channel_avg     (channel_avg),
    .drp_timeout     (drp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial vld_cnt = 0;
  always @(negedge clk) begin
    if (DEN) begin
      den_log.push_back(DADDR);
      den_cyc.push_back(cyc);
    end
    if (network_valid) vld_cnt++;
  end

  // DRP responder: answers each DEN after 'lat' cycles with the next table sample of that channel.
  initial begin
    int rd_idx [NCH];
    int my_epoch;
    int c;
    DRDY = 1'b0;
    DO = '0;
    my_epoch = 0;
    for (int i = 0; i < NCH; i++) rd_idx[i] = 0;
    forever begin
      @(negedge clk);
      DRDY = 1'b0;
      if (my_epoch != epoch) begin
        for (int i = 0; i < NCH; i++) rd_idx[i] = 0;
        my_epoch = epoch;
      end
      if (DEN && rst_n && !(withhold_en && DADDR == withhold_addr)) begin
        c = int'(DADDR) - 16;
        if (c < 0 || c >= NCH) c = 0;
        if (lat > 1) repeat (lat - 1) @(negedge clk);
        DO = {12'(tbl[rd_idx[c] % NSAMP][c]), 4'($urandom)};
        rd_idx[c]++;
        DRDY = 1'b1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_avg(input int c);
    int s;
    s = 0;
    for (int k = 0; k < NSAMP; k++) s += tbl[k][c];
    return s / NSAMP;
  endfunction

  task automatic check_decision(input string tag);
    int best;
    logic [47:0] pack;
    pack = '0;
    best = 0;
    for (int c = 0; c < NCH; c++) begin
      pack[12*c +: 12] = 12'(model_avg(c));
      if (model_avg(c) > model_avg(best)) best = c;
    end
    check_eq({tag, "_idx"}, 64'(network_output), 64'(best));
    check_eq({tag, "_above"}, 64'(above_threshold), 64'(model_avg(best) >= int'(threshold)));
    check_eq({tag, "_avg"}, 64'(channel_avg), 64'(pack));
  endtask

  task automatic run_decision(input string tag, output int base);
    int b_vld;
    int den_at_valid;
    bit got;
    base = den_log.size();
    b_vld = vld_cnt;
    den_at_valid = 0;
    got = 0;
    epoch++;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      if (network_valid) begin
        got = 1;
        enable = 1'b0;
        den_at_valid = den_log.size() - base;
      end
    end
    check_eq({tag, "_valid_seen"}, 64'(got), 64'd1);
    check_eq({tag, "_reads_before_valid"}, 64'(den_at_valid), 64'(NCH * NSAMP));
    repeat (20) @(negedge clk);
    check_eq({tag, "_valid_pulses"}, 64'(vld_cnt - b_vld), 64'd1);
    check_decision(tag);
  endtask

  task automatic wait_dens(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (den_log.size() >= target) ok = 1;
    end
  endtask

  initial begin
    int base;
    int mx;
    int delta;
    bit ok;
    checks = 0;
    failures = 0;
    epoch = 0;
    lat = 3;
    withhold_en = 0;
    withhold_addr = 7'h12;
    rst_n = 1'b0;
    enable = 1'b0;
    trigger_mode = 1'b1;
    threshold = 12'h400;
    timeout_clear = 1'b0;
    BUSY = 1'b0;
    EOS = 1'b0;
    for (int k = 0; k < NSAMP; k++) for (int c = 0; c < NCH; c++) tbl[k][c] = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_den", 64'(DEN), 64'd0);
    check_eq("rst_daddr", 64'(DADDR), 64'd0);
    check_eq("rst_valid", 64'(network_valid), 64'd0);
    check_eq("rst_out", 64'(network_output), 64'd0);
    check_eq("rst_above", 64'(above_threshold), 64'd0);
    check_eq("rst_avg", 64'(channel_avg), 64'd0);
    check_eq("rst_timeout", 64'(drp_timeout), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Distinct per-channel levels, winner is channel 1.
    for (int k = 0; k < NSAMP; k++) begin
      tbl[k][0] = 'h100; tbl[k][1] = 'h800; tbl[k][2] = 'h300; tbl[k][3] = 'h200;
    end
    threshold = 12'h400;
    run_decision("basic", base);
    for (int i = 0; i < NCH; i++) check_eq("basic_daddr", 64'(den_log[base + i]), 64'(7'h10 + i));
    check_eq("basic_avg_const", 64'(channel_avg), 64'h200_300_800_100);
    check_eq("tie_rules_di_dwe", 64'({DI, DWE}), 64'd0);

    // All equal: lowest index wins, below threshold.
    for (int k = 0; k < NSAMP; k++) for (int c = 0; c < NCH; c++) tbl[k][c] = 'h555;
    threshold = 12'h600;
    run_decision("tie", base);
    check_eq("tie_idx_const", 64'(network_output), 64'd0);

    // Averaging across rounds on ch0.
    for (int k = 0; k < NSAMP; k++) for (int c = 0; c < NCH; c++) tbl[k][c] = 0;
    tbl[0][0] = 'h100; tbl[1][0] = 'h200; tbl[2][0] = 'h300; tbl[3][0] = 'h400;
    threshold = 12'h280;
    run_decision("avg4", base);
    check_eq("avg4_ch0", 64'(channel_avg[11:0]), 64'h280);

    for (int it = 0; it < 6; it++) begin
      lat = $urandom_range(1, 6);
      for (int k = 0; k < NSAMP; k++)
        for (int c = 0; c < NCH; c++)
          tbl[k][c] = (it == 3) ? 'hFFF : int'($urandom_range(0, 4095));
      mx = 0;
      for (int c = 0; c < NCH; c++) if (model_avg(c) > mx) mx = model_avg(c);
      if (it == 2) threshold = 12'(mx);
      else if (it == 4) threshold = 12'(mx + 1);
      else threshold = 12'($urandom);
      run_decision($sformatf("rand%0d", it), base);
    end
    lat = 3;

    // Mode 0: nothing happens until EOS, then exactly one round.
    trigger_mode = 1'b0;
    base = den_log.size();
    @(negedge clk);
    enable = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("eos_idle_dens", 64'(den_log.size() - base), 64'd0);
    EOS = 1'b1;
    @(negedge clk);
    EOS = 1'b0;
    repeat (60) @(negedge clk);
    check_eq("eos_round_dens", 64'(den_log.size() - base), 64'd4);
    if (den_log.size() - base >= 4)
      check_eq("eos_last_daddr", 64'(den_log[base + 3]), 64'h13);
    enable = 1'b0;
    trigger_mode = 1'b1;
    repeat (5) @(negedge clk);

    // Drop enable during ch1's read.
    lat = 5;
    base = den_log.size();
    mx = vld_cnt;
    epoch++;
    enable = 1'b1;
    wait_dens(base + 2, ok);
    check_eq("drop_saw_ch1", 64'(ok), 64'd1);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("drop_dens", 64'(den_log.size() - base), 64'd2);
    check_eq("drop_no_valid", 64'(vld_cnt - mx), 64'd0);
    lat = 3;
    for (int k = 0; k < NSAMP; k++) begin
      tbl[k][0] = 'h100; tbl[k][1] = 'h800; tbl[k][2] = 'h300; tbl[k][3] = 'h200;
    end
    threshold = 12'h400;
    run_decision("after_drop", base);

    // DRP timeout on ch2.
    withhold_en = 1;
    withhold_addr = 7'h12;
    base = den_log.size();
    mx = vld_cnt;
    epoch++;
    @(negedge clk);
    enable = 1'b1;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (drp_timeout) ok = 1;
    end
    check_eq("tmo_seen", 64'(ok), 64'd1);
    delta = (den_log.size() > base + 2) ? cyc - den_cyc[base + 2] : 0;
    check_eq("tmo_latency", 64'(delta >= 255 && delta <= 257), 64'd1);
    wait_dens(base + 4, ok);
    enable = 1'b0;
    check_eq("tmo_restart_seen", 64'(ok), 64'd1);
    if (ok) check_eq("tmo_restart_daddr", 64'(den_log[base + 3]), 64'h10);
    repeat (20) @(negedge clk);
    check_eq("tmo_no_valid", 64'(vld_cnt - mx), 64'd0);
    check_eq("tmo_sticky", 64'(drp_timeout), 64'd1);
    timeout_clear = 1'b1;
    @(negedge clk);
    timeout_clear = 1'b0;
    @(negedge clk);
    check_eq("tmo_cleared", 64'(drp_timeout), 64'd0);

    // Async reset while waiting for DRDY.
    withhold_addr = 7'h10;
    base = den_log.size();
    enable = 1'b1;
    wait_dens(base + 1, ok);
    check_eq("arst_den_seen", 64'(ok), 64'd1);
    check_eq("arst_pre_avg_nonzero", 64'(channel_avg != 0), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_den", 64'(DEN), 64'd0);
    check_eq("arst_avg", 64'(channel_avg), 64'd0);
    check_eq("arst_out", 64'(network_output), 64'd0);
    check_eq("arst_above", 64'(above_threshold), 64'd0);
    check_eq("arst_daddr", 64'(DADDR), 64'd0);
    enable = 1'b0;
    withhold_en = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
